mul_final_add: RTL and testbench

//   Back end of the 64-bit Booth/Wallace multiplier. Accepts the two 128-bit

---
 rtl/mul_pkg.sv | 17 +
 rtl/mul_cpa64.sv | 14 +
 rtl/mul_final_add.sv | 130 +++++++++++++
 tb/tb_mul_final_add.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared multiplier definitions: operand/product widths and the result-select bundle
// used by the Booth encoder, EXU issue and the final-add back end.
package mul_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned PROD_W = 2 * XLEN;

  typedef struct packed {
    logic high;  // take product[PROD_W-1:XLEN]
    logic word;  // take sext(product[31:0]); overrides high
  } mul_sel_t;

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
    return {{(XLEN - 32){v[31]}}, v[31:0]};
  endfunction

endpackage

// File: rtl/mul_cpa64.sv
// Carry-propagate adder slice: sum_o = a_i + b_i + cin_i with carry out.
module mul_cpa64 #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};

endmodule

// File: rtl/mul_final_add.sv
// Multiplier back end: resolves the Wallace sum/carry pair with a two-stage CPA
// (low half, then high half) and delivers the selected result over valid/ready.
module mul_final_add
  import mul_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PROD_W-1:0]   in_sum,
  input  logic [PROD_W-1:0]   in_carry,
  input  logic                in_high,
  input  logic                in_word,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_result,
  output logic [TAG_W-1:0]    out_tag
);

  logic             s1_valid_q, s1_valid_d;
  logic [XLEN-1:0]  s1_lo_q;
  logic             s1_c64_q;
  logic [XLEN-1:0]  s1_sum_hi_q;
  logic [XLEN-1:0]  s1_carry_hi_q;
  mul_sel_t         s1_sel_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q;

  logic             out_adv, s1_adv, accept;
  logic [XLEN-1:0]  lo_sum, hi_sum;
  logic             lo_cout, hi_cout;

  // in_ready depends on out_ready only, never on in_valid.
  assign out_adv  = !out_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && out_adv;
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready && !flush;

  mul_cpa64 #(
    .W (XLEN)
  ) u_cpa_lo (
    .a_i    (in_sum[XLEN-1:0]),
    .b_i    (in_carry[XLEN-1:0]),
    .cin_i  (1'b0),
    .sum_o  (lo_sum),
    .cout_o (lo_cout)
  );

  // Carry out of bit 127 is dropped: the product is taken mod 2^128.
  mul_cpa64 #(
    .W (XLEN)
  ) u_cpa_hi (
    .a_i    (s1_sum_hi_q),
    .b_i    (s1_carry_hi_q),
    .cin_i  (s1_c64_q),
    .sum_o  (hi_sum),
    .cout_o (hi_cout)
  );

  logic unused_hi_cout;
  assign unused_hi_cout = hi_cout;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (out_adv) begin
      out_valid_d = s1_valid_q;
    end

    if (s1_sel_q.word) begin
      out_result_d = sext_word(s1_lo_q);
    end else if (s1_sel_q.high) begin
      out_result_d = hi_sum;
    end else begin
      out_result_d = s1_lo_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_lo_q       <= '0;
      s1_c64_q      <= 1'b0;
      s1_sum_hi_q   <= '0;
      s1_carry_hi_q <= '0;
      s1_sel_q      <= '0;
      s1_tag_q      <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_tag_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        s1_lo_q       <= lo_sum;
        s1_c64_q      <= lo_cout;
        s1_sum_hi_q   <= in_sum[PROD_W-1:XLEN];
        s1_carry_hi_q <= in_carry[PROD_W-1:XLEN];
        s1_sel_q      <= '{high: in_high, word: in_word};
        s1_tag_q      <= in_tag;
      end
      if (s1_adv) begin
        out_result_q <= out_result_d;
        out_tag_q    <= s1_tag_q;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_mul_final_add.sv
// Bench for mul_final_add: directed vectors with literal expectations plus a
// queue-based reference model checked every cycle.
module tb_mul_final_add;

  logic         clock = 1'b0;
  logic         reset, flush, in_valid, in_ready;
  logic [127:0] in_sum, in_carry;
  logic         in_high, in_word;
  logic [4:0]   in_tag;
  logic         out_valid, out_ready;
  logic [63:0]  out_result;
  logic [4:0]   out_tag;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    int          t;
  } ent_t;
  ent_t q[$];

  always #5 clock = ~clock;

  mul_final_add #(
    .TAG_W (5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .in_high    (in_high),
    .in_word    (in_word),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [127:0] s, input logic [127:0] c,
                                             input logic hi, input logic wd);
    logic [127:0] p;
    p = s + c;
    if (wd) return {{32{p[31]}}, p[31:0]};
    if (hi) return p[127:64];
    return p[63:0];
  endfunction

  // Reference: ops in flight, oldest first; an op reaches the output two cycles
  // after acceptance unless something older blocks, and capacity is two.
  always @(negedge clock) begin
    ent_t e;
    logic exp_vld;
    cyc++;
    if (reset) begin
      q.delete();
    end else begin
      exp_vld = (q.size() > 0) && (cyc - q[0].t >= 2);
      chk("m_out_valid", out_valid, exp_vld);
      chk("m_in_ready", in_ready, (q.size() < 2) || out_ready);
      if (out_valid) begin
        chk("m_out_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("m_result", out_result, q[0].res);
          chk("m_tag", out_tag, q[0].tag);
        end
      end
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (flush) begin
        q.delete();
      end else if (in_valid && in_ready) begin
        e.res = ref_result(in_sum, in_carry, in_high, in_word);
        e.tag = in_tag;
        e.t   = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic drive(input logic [127:0] s, input logic [127:0] c, input logic hi,
                       input logic wd, input logic [4:0] tag);
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    in_high  = hi;
    in_word  = wd;
    in_tag   = tag;
  endtask

  // Issue one op with out_ready high and check it two cycles after acceptance.
  task automatic issue_check(input string name, input logic [127:0] s, input logic [127:0] c,
                             input logic hi, input logic wd, input logic [4:0] tag,
                             input logic [63:0] exp);
    @(posedge clock); #1;
    drive(s, c, hi, wd, tag);
    @(negedge clock);
    chk({name, "_in_ready"}, in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk({name, "_lat1_valid"}, out_valid, 0);
    @(negedge clock);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_result"}, out_result, exp);
    chk({name, "_tag"}, out_tag, tag);
  endtask

  initial begin
    logic [127:0] rs, rc;
    logic [4:0]   rtag;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(128'h1234, 128'h5678, 1'b0, 1'b0, 5'd9);

    // Reset with in_valid held high.
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);

    // Carry from the low half into the high half.
    issue_check("carry_hi", 128'hFFFF_FFFF_FFFF_FFFF, 128'h1, 1'b1, 1'b0, 5'd1, 64'h1);
    issue_check("carry_lo", 128'hFFFF_FFFF_FFFF_FFFF, 128'h1, 1'b0, 1'b0, 5'd2, 64'h0);
    issue_check("wrap_hi", {128{1'b1}}, 128'h1, 1'b1, 1'b0, 5'd3, 64'h0);
    issue_check("plain_lo", 128'h5, 128'h7, 1'b0, 1'b0, 5'd4, 64'hC);

    // MULW sign extension, word overriding high.
    issue_check("mulw_neg", 128'h8000_0000, 128'h0, 1'b1, 1'b1, 5'd5, 64'hFFFF_FFFF_8000_0000);
    issue_check("mulw_pos", 128'h7FFF_FFFF, 128'h0, 1'b1, 1'b1, 5'd6, 64'h0000_0000_7FFF_FFFF);

    // Backpressure with tags 1,2,3 back to back.
    @(posedge clock); #1;
    out_ready = 1'b0;
    drive(128'h10, 128'h1, 1'b0, 1'b0, 5'd1);
    @(posedge clock); #1;
    drive(128'h20, 128'h2, 1'b0, 1'b0, 5'd2);
    @(posedge clock); #1;
    drive(128'h30, 128'h3, 1'b0, 1'b0, 5'd3);
    repeat (3) begin
      @(negedge clock);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_tag", out_tag, 1);
      chk("bp_hold_result", out_result, 64'h11);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_tag", out_tag, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("bp_tag2", out_tag, 2);
    chk("bp_res2", out_result, 64'h22);
    @(negedge clock);
    chk("bp_tag3", out_tag, 3);
    chk("bp_res3", out_result, 64'h33);
    @(negedge clock);
    chk("bp_drained", out_valid, 0);

    // Flush with s1 and out occupied and a new op presented.
    @(posedge clock); #1;
    out_ready = 1'b0;
    drive(128'h40, 128'h0, 1'b0, 1'b0, 5'd4);
    @(posedge clock); #1;
    drive(128'h50, 128'h0, 1'b0, 1'b0, 5'd5);
    @(posedge clock); #1;
    drive(128'h60, 128'h0, 1'b0, 1'b0, 5'd6);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    @(negedge clock);
    chk("fl_no_ghost", out_valid, 0);
    out_ready = 1'b1;
    issue_check("fl_next", 128'h70, 128'h7, 1'b0, 1'b0, 5'd7, 64'h77);

    // Random traffic against the model.
    rtag = 5'd0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge clock); #1;
      rs = {$urandom, $urandom, $urandom, $urandom};
      rc = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rc[63:0] = ~rs[63:0] + 64'($urandom_range(0, 2));
      drive(rs, rc, 1'($urandom), 1'($urandom_range(0, 3) == 0), rtag);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 199) == 0);
      if (in_valid && in_ready && !flush) rtag = rtag + 5'd1;
    end
    @(posedge clock); #1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clock);
    chk("rand_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
